// File: rtl/alarm_clock_core.sv
// alarm_clock_core: timekeeping core for the digital alarm clock.
// Divides clk down to a 1 Hz tick and keeps HH:MM:SS in BCD (hours 00..23
// internally). It holds one alarm time and runs an IDLE/RINGING/SNOOZED
// state machine. The display can be shown in 12h or 24h form.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   ena                   tick enable (freezes prescaler and time when 0)
//   set_time, set_alarm   level-sensitive edit modes (set_time has priority)
//   inc_hour, inc_min     1-cycle increment pulses for the selected target
//   alarm_en, snooze      alarm armed level / snooze pulse
//   mode_12h              1 selects 12h display
//   disp_hh/mm/ss, pm     BCD display of the time, or of the alarm while editing it
//   ring, sec_tick        alarm sounding / registered once-per-second pulse
module alarm_clock_core #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       mode_12h,
  output logic [7:0] disp_hh,
  output logic [7:0] disp_mm,
  output logic [7:0] disp_ss,
  output logic       pm,
  output logic       ring,
  output logic       sec_tick
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZED} state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction

  function automatic logic [6:0] to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] b);
    logic [6:0] t;
    t = b / 7'd10;
    return {t[3:0], 4'(b - t * 7'd10)};
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0]    al_hh_q, al_hh_d, al_mm_q, al_mm_d;
  logic [7:0]    sn_hh_q, sn_hh_d, sn_mm_q, sn_mm_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick_q;
  state_t        st_q, st_d;
  logic          run, tick;

  // Prescaler and time/alarm registers
  always_comb begin
    run     = ena && !set_time;
    tick    = run && (pre_q == PW'(TICK_DIV - 1));
    pre_d   = pre_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    if (set_time) begin
      pre_d = '0;
      ss_d  = '0;
      if (inc_min)  mm_d = (mm_q == 8'h59) ? '0 : bcd_inc(mm_q);
      if (inc_hour) hh_d = (hh_q == 8'h23) ? '0 : bcd_inc(hh_q);
    end else begin
      if (run) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        ss_d = (ss_q == 8'h59) ? '0 : bcd_inc(ss_q);
        if (ss_q == 8'h59) begin
          mm_d = (mm_q == 8'h59) ? '0 : bcd_inc(mm_q);
          if (mm_q == 8'h59) hh_d = (hh_q == 8'h23) ? '0 : bcd_inc(hh_q);
        end
      end
      if (set_alarm) begin
        if (inc_min)  al_mm_d = (al_mm_q == 8'h59) ? '0 : bcd_inc(al_mm_q);
        if (inc_hour) al_hh_d = (al_hh_q == 8'h23) ? '0 : bcd_inc(al_hh_q);
      end
    end
  end

  // Alarm FSM. Matches compare against the post-tick time (hh_d/mm_d/ss_d).
  always_comb begin
    logic [6:0] sm, sh;
    st_d    = st_q;
    cnt_d   = cnt_q;
    sn_hh_d = sn_hh_q;
    sn_mm_d = sn_mm_q;
    sm      = to_bin(mm_q) + 7'(SNOOZE_MIN);
    sh      = to_bin(hh_q);
    if (sm >= 7'd60) begin
      sm = sm - 7'd60;
      sh = sh + 7'd1;
    end
    if (sh >= 7'd24) sh = sh - 7'd24;
    unique case (st_q)
      S_IDLE: begin
        if (tick && alarm_en && {hh_d, mm_d, ss_d} == {al_hh_q, al_mm_q, 8'h00}) begin
          st_d  = S_RINGING;
          cnt_d = '0;
        end
      end
      S_RINGING: begin
        if (set_time || !alarm_en) begin
          st_d = S_IDLE;
        end else if (snooze) begin
          st_d    = S_SNOOZED;
          sn_hh_d = to_bcd(sh);
          sn_mm_d = to_bcd(sm);
        end else if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(RING_SEC)) st_d = S_IDLE;
        end
      end
      S_SNOOZED: begin
        if (set_time || !alarm_en) begin
          st_d = S_IDLE;
        end else if (tick && {hh_d, mm_d, ss_d} == {sn_hh_q, sn_mm_q, 8'h00}) begin
          st_d  = S_RINGING;
          cnt_d = '0;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      al_hh_q <= '0;
      al_mm_q <= '0;
      sn_hh_q <= '0;
      sn_mm_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      st_q    <= S_IDLE;
    end else begin
      pre_q   <= pre_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      sn_hh_q <= sn_hh_d;
      sn_mm_q <= sn_mm_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick;
      st_q    <= st_d;
    end
  end

  assign ring     = (st_q == S_RINGING);
  assign sec_tick = tick_q;

  // Display mux and 12h conversion
  always_comb begin
    logic       show_al;
    logic [7:0] src_hh;
    logic [6:0] hb;
    show_al = set_alarm && !set_time;
    src_hh  = show_al ? al_hh_q : hh_q;
    disp_mm = show_al ? al_mm_q : mm_q;
    disp_ss = show_al ? 8'h00   : ss_q;
    hb      = to_bin(src_hh);
    disp_hh = src_hh;
    pm      = 1'b0;
    if (mode_12h) begin
      if (hb == 7'd0) begin
        disp_hh = 8'h12;
      end else if (hb == 7'd12) begin
        pm = 1'b1;
      end else if (hb > 7'd12) begin
        disp_hh = to_bcd(hb - 7'd12);
        pm      = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
module tb_alarm_clock_core;
  logic       clk = 1'b0;
  logic       rst, ena, set_time, set_alarm, inc_hour, inc_min;
  logic       alarm_en, snooze, mode_12h;
  logic [7:0] disp_hh, disp_mm, disp_ss;
  logic       pm, ring, sec_tick;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned ticks;
  int unsigned k;

  always #5 clk = ~clk;

  alarm_clock_core #(.TICK_DIV(4), .SNOOZE_MIN(9), .RING_SEC(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .set_time(set_time), .set_alarm(set_alarm),
    .inc_hour(inc_hour), .inc_min(inc_min), .alarm_en(alarm_en), .snooze(snooze),
    .mode_12h(mode_12h), .disp_hh(disp_hh), .disp_mm(disp_mm), .disp_ss(disp_ss),
    .pm(pm), .ring(ring), .sec_tick(sec_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check_eq({tag, "_hh"}, {24'h0, disp_hh}, {24'h0, h});
    check_eq({tag, "_mm"}, {24'h0, disp_mm}, {24'h0, m});
    check_eq({tag, "_ss"}, {24'h0, disp_ss}, {24'h0, s});
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_h(input int unsigned n);
    repeat (n) begin
      inc_hour = 1'b1;
      step(1);
      inc_hour = 1'b0;
    end
  endtask

  task automatic pulse_m(input int unsigned n);
    repeat (n) begin
      inc_min = 1'b1;
      step(1);
      inc_min = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    {ena, set_time, set_alarm, inc_hour, inc_min, alarm_en, snooze, mode_12h} = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Alarm 06:30, time 06:29:00, then run until the alarm fires at 06:30:00.
  task automatic setup_ring(input string tag);
    do_reset();
    set_alarm = 1'b1;
    pulse_h(6);
    pulse_m(30);
    check_disp({tag, "_al"}, 8'h06, 8'h30, 8'h00);
    set_alarm = 1'b0;
    set_time  = 1'b1;
    pulse_h(6);
    pulse_m(29);
    alarm_en = 1'b1;
    set_time = 1'b0;
    ena      = 1'b1;
    step(59 * 4);
    check_disp({tag, "_pre"}, 8'h06, 8'h29, 8'h59);
    check_eq({tag, "_pre_ring"}, 32'(ring), 32'd0);
    step(4);
    check_disp({tag, "_at"}, 8'h06, 8'h30, 8'h00);
    check_eq({tag, "_ring"}, 32'(ring), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {ena, set_time, set_alarm, inc_hour, inc_min, alarm_en, snooze, mode_12h} = '0;

    // 1: reset state, tick count, ena freeze
    do_reset();
    check_disp("t1_rst", 8'h00, 8'h00, 8'h00);
    check_eq("t1_rst_ring", 32'(ring), 32'd0);
    check_eq("t1_rst_tick", 32'(sec_tick), 32'd0);
    mode_12h = 1'b1;
    #1;
    check_eq("t1_rst_12h_hh", 32'(disp_hh), 32'h12);
    check_eq("t1_rst_12h_pm", 32'(pm), 32'd0);
    mode_12h = 1'b0;
    ena   = 1'b1;
    ticks = 0;
    repeat (16) begin
      step(1);
      if (sec_tick) ticks++;
    end
    check_eq("t1_ticks", ticks, 32'd4);
    check_disp("t1_run", 8'h00, 8'h00, 8'h04);
    ena   = 1'b0;
    ticks = 0;
    repeat (8) begin
      step(1);
      if (sec_tick) ticks++;
    end
    check_eq("t1_frozen_ticks", ticks, 32'd0);
    check_disp("t1_frozen", 8'h00, 8'h00, 8'h04);

    // 2: time set wraps and midnight rollover
    do_reset();
    ena      = 1'b1;
    set_time = 1'b1;
    pulse_h(23);
    pulse_m(59);
    check_disp("t2_set", 8'h23, 8'h59, 8'h00);
    pulse_m(1);
    check_disp("t2_mwrap", 8'h23, 8'h00, 8'h00);
    pulse_h(1);
    check_disp("t2_hwrap", 8'h00, 8'h00, 8'h00);
    pulse_h(23);
    pulse_m(59);
    set_time = 1'b0;
    step(4);
    check_disp("t2_1s", 8'h23, 8'h59, 8'h01);
    step(58 * 4);
    check_disp("t2_59s", 8'h23, 8'h59, 8'h59);
    step(4);
    check_disp("t2_midnight", 8'h00, 8'h00, 8'h00);

    // 3: 12h display
    do_reset();
    mode_12h = 1'b1;
    set_time = 1'b1;
    pulse_m(5);
    check_disp("t3_0005", 8'h12, 8'h05, 8'h00);
    check_eq("t3_0005_pm", 32'(pm), 32'd0);
    mode_12h = 1'b0;
    #1;
    check_eq("t3_24h_hh", 32'(disp_hh), 32'h00);
    do_reset();
    mode_12h = 1'b1;
    set_time = 1'b1;
    pulse_h(12);
    check_eq("t3_1200_hh", 32'(disp_hh), 32'h12);
    check_eq("t3_1200_pm", 32'(pm), 32'd1);
    pulse_h(1);
    pulse_m(30);
    check_disp("t3_1330", 8'h01, 8'h30, 8'h00);
    check_eq("t3_1330_pm", 32'(pm), 32'd1);
    pulse_h(10);
    check_eq("t3_2330_hh", 32'(disp_hh), 32'h11);
    check_eq("t3_2330_pm", 32'(pm), 32'd1);
    mode_12h = 1'b0;
    #1;
    check_eq("t3_24h_pm", 32'(pm), 32'd0);

    // 4: ring timeout after three ticks
    setup_ring("t4");
    step(8);
    check_eq("t4_ring_2s", 32'(ring), 32'd1);
    step(4);
    check_eq("t4_timeout", 32'(ring), 32'd0);
    check_disp("t4_time", 8'h06, 8'h30, 8'h03);

    // 5: snooze and re-ring, then disarm
    setup_ring("t5");
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    check_eq("t5_snoozed", 32'(ring), 32'd0);
    k = 0;
    while (!ring && k < 2400) begin
      step(1);
      k++;
    end
    check_eq("t5_rering", 32'(ring), 32'd1);
    check_disp("t5_rering", 8'h06, 8'h39, 8'h00);
    alarm_en = 1'b0;
    step(1);
    check_eq("t5_disarm", 32'(ring), 32'd0);

    // 6: asynchronous reset mid-ring and mid-prescale
    setup_ring("t6");
    step(2);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_ring", 32'(ring), 32'd0);
    check_eq("t6_tick", 32'(sec_tick), 32'd0);
    check_eq("t6_pm", 32'(pm), 32'd0);
    check_disp("t6_rst", 8'h00, 8'h00, 8'h00);
    step(1);
    rst = 1'b0;
    step(3);
    check_disp("t6_pre0", 8'h00, 8'h00, 8'h00);
    step(1);
    check_disp("t6_first", 8'h00, 8'h00, 8'h01);
    check_eq("t6_first_tick", 32'(sec_tick), 32'd1);
    check_eq("t6_no_ring", 32'(ring), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
